// File: rtl/fifo_pkg.sv
// Shared defaults and FSM encoding for the fifo_s read-side burst engine.
package fifo_pkg;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned PTR_ADDR = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/out_skid_buf.sv
// Two-entry in-order output buffer; the head entry drives the stream while the
// second entry absorbs the word already in flight when the consumer stalls.
module out_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = fifo_pkg::WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] ent0_q;
    logic [WIDTH-1:0] ent1_q;
    logic [1:0]       occ_q;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop && (occ_q != 2'd0);
    assign push_ok = push && ((occ_q != 2'd2) || pop_ok);

    // Entry 0 is always the head; simultaneous push and pop keep occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        ent0_q <= wdata;
                    end else begin
                        ent1_q <= wdata;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        ent0_q <= wdata;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= wdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign occ  = occ_q;
    assign head = ent0_q;

endmodule

// File: rtl/fifo_rd_burst.sv
// Read-side burst engine for fifo_s: pops len_i words without ever reading an
// empty FIFO and streams them downstream over valid/ready with a last marker.
module fifo_rd_burst
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = fifo_pkg::WIDTH,
    parameter int unsigned DEPTH = fifo_pkg::DEPTH,
    parameter int unsigned LEN_W = $clog2(DEPTH) + 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             rd_en_o,
    input  logic [WIDTH-1:0] rdata_i,
    input  logic             empty_i,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_last_o,
    input  logic             m_ready_i
);

    rd_state_e        state_q;
    rd_state_e        state_d;
    logic [LEN_W-1:0] rem_q;
    logic [LEN_W-1:0] out_q;
    logic             inflight_q;
    logic             load;
    logic             beat;
    logic [1:0]       buf_occ;
    logic [2:0]       pending;
    logic             room;

    assign beat = m_valid_o && m_ready_i;

    // Words already committed to the buffer, less the one leaving this cycle,
    // must leave space for the pop being issued now.
    assign pending = 3'(buf_occ) + 3'(inflight_q);
    assign room    = (pending - 3'(beat)) < 3'd2;

    assign rd_en_o = (state_q == READ) && (rem_q != '0) && !empty_i && room;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        state_d = READ;
                        load    = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                if (rd_en_o && (rem_q == LEN_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((beat && (out_q == LEN_W'(1))) || (out_q == '0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Remaining pops and remaining beats; both saturate at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q      <= '0;
            out_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd_en_o;
            if (load) begin
                rem_q <= len_i;
                out_q <= len_i;
            end else begin
                if (rd_en_o && (rem_q != '0)) begin
                    rem_q <= rem_q - LEN_W'(1);
                end
                if (beat && (out_q != '0)) begin
                    out_q <= out_q - LEN_W'(1);
                end
            end
        end
    end

    out_skid_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (inflight_q),
        .wdata (rdata_i),
        .pop   (m_ready_i),
        .occ   (buf_occ),
        .head  (m_data_o)
    );

    assign m_valid_o = (buf_occ != 2'd0);
    assign m_last_o  = m_valid_o && (out_q == LEN_W'(1));
    assign busy_o    = (state_q == READ) || (state_q == DRAIN);
    assign done_o    = (state_q == DONE);

endmodule
